mc_port_responder: RTL and testbench
====================================

# mc_port_responder

Synthesizable memory-controller port responder: the MC-side end of the personality request/response interface. It accepts load/store requests, services them in order from an on-chip 64-bit RAM, and returns load data tagged with the requester's rdctl. It sits opposite a personality unit such as the pointer-chasing load engine, for standalone simulation and for FPGA bring-up without the real MC.

## Interface
- DEPTH_LOG2, 10: RAM depth is 2^DEPTH_LOG2 64-bit words.
- LATENCY, 4: cycles from request presentation to mc_rsp_push on an idle unit; legal range 3..16.
- QDEPTH, 32: request queue entries; power of two.
- RSPQ, 8: response queue entries; power of two.
- clk in 1: single clock.
- reset in 1: asynchronous, active-high.
- mc_req_ld in 1: load request valid.
- mc_req_st in 1: store request valid.
- mc_req_vadr in 48: byte address; 8-byte aligned.
- mc_req_wrd_rdctl in 64: store data when st; for ld, [31:0] is the rdctl tag.
- mc_rd_rq_stall out 1: requester must stop issuing loads.
- mc_wr_rq_stall out 1: requester must stop issuing stores.
- mc_rsp_rdctl out 32: tag of the returned load.
- mc_rsp_data out 64: load data.
- mc_rsp_push out 1: response valid, one cycle per response.
- mc_rsp_stall in 1: consumer back-pressure.
- err out 1: sticky protocol error. Cleared only by reset.
- req_count out 32: total accepted requests. Wraps at 2^32.

## Operation
- Request accepted on any clk edge with ld or st high. No ready handshake, so stall is advisory with skid margin.
- Request queue entry is {is_st, word address, 64-bit payload}.
  - Word address = vadr[DEPTH_LOG2+2:3].
- ld and st both high: accepted as a load, err set.
- vadr[2:0] != 0: address bits ignored, err set.
- Request queue full and a new request arrives: request dropped, err set, queue unchanged.
- Both stall outputs are the same registered signal: high when request queue count >= QDEPTH-4. This covers the requester's registered-stall path of 2 cycles of skid plus margin.
- Pop rule: queue head is popped when the queue is non-empty and (response-queue count + loads in flight) < RSPQ.
  - A store pop is always allowed.
- Store pop writes the RAM and produces no response.
- Load pop reads the RAM with synchronous read. It passes through LATENCY-3 delay stages, then is pushed into the response queue with its tag.
- Strict in-order service. A load popped after a store to the same word returns the stored data.
- mc_rsp_stall is registered internally.
  - mc_rsp_push = response queue non-empty and registered stall low.
  - So at most one push occurs in the cycle after the consumer raises stall.
- Reset mid-operation: both queues and the pipeline are flushed, in-flight loads are discarded, and RAM contents are retained.

## Timing
- Reset values: mc_rd_rq_stall=0, mc_wr_rq_stall=0, mc_rsp_push=0, mc_rsp_rdctl=0, mc_rsp_data=0, err=0, req_count=0.
- Idle load presented in cycle 0:
  - cycle 1: pop and RAM read.
  - cycle LATENCY-1: enters response queue.
  - cycle LATENCY: mc_rsp_push=1.
- Sustained throughput is one request per cycle while no stall is active.
- Stall rises 1 cycle after the queue count reaches QDEPTH-4. It falls 1 cycle after the count drops below QDEPTH-4.
- Simultaneous push and pop on the same edge leave the queue count unchanged. A full queue with a simultaneous pop accepts the new request.
- Response outputs are registered and are held stable only for the push cycle. mc_rsp_rdctl and mc_rsp_data are don't-care otherwise.

## Configuration
- MC_ADDR_CHECK_EN defined:
  - Any vadr at or above 8*2^DEPTH_LOG2 sets err.
  - A load to such an address returns data 0 with its correct tag.
  - A store to such an address is discarded.
- Undefined: high address bits are silently ignored, so addresses alias modulo the RAM size.

## Structure
- Package mc_port_pkg holds:
  - Widths: VADR_W=48, WRD_W=64, RDCTL_W=32.
  - The request-queue entry struct and the response-queue entry struct {rdctl, data}.
- Sub-module mc_port_ram: simple dual-port synchronous RAM with write-first behaviour.
- Both queues use the team's existing fifo primitive.

## Test plan
- Preload word 5 = 0xDEADBEEF. Issue ld at vadr 0x28 with rdctl 0x7 -> push at cycle 4 with data 0xDEADBEEF and rdctl 0x7.
- st 0x1234 to vadr 0x40, then ld 0x40 on the next cycle -> single response with data 0x1234. No response for the store.
- Issue 40 back-to-back loads, honouring stall with 2-cycle registered reaction -> stall asserted. All 40 responses arrive in order with no drop and err=0.
- Hold mc_rsp_stall high for 20 cycles during a burst of 16 loads -> at most 1 push after the stall edge, then 0 pushes. Remaining responses arrive in order after release.
- ld and st together, then a misaligned vadr 0x43 -> err=1 and stays 1. Async reset mid-burst -> all outputs 0 immediately and err cleared.
- With MC_ADDR_CHECK_EN, ld at 0x2000 (DEPTH_LOG2=10) -> data 0, correct tag, err=1.

Source files
------------

// File: rtl/mc_port_pkg.sv
// rtl/mc_port_pkg.sv - shared widths and queue entry types for mc_port_responder
package mc_port_pkg;

    localparam int VADR_W  = 48;
    localparam int WRD_W   = 64;
    localparam int RDCTL_W = 32;
    // Word-address field is sized for the largest supported RAM (DEPTH_LOG2 <= 16).
    localparam int WADR_W  = 16;

    typedef struct packed {
        logic              is_st;
        logic              oob;      // address beyond RAM; only ever set with MC_ADDR_CHECK_EN
        logic [WADR_W-1:0] wadr;
        logic [WRD_W-1:0]  payload;  // store data, or rdctl tag in [31:0] for loads
    } req_entry_t;

    typedef struct packed {
        logic [RDCTL_W-1:0] rdctl;
        logic [WRD_W-1:0]   data;
    } rsp_entry_t;

endpackage

// File: rtl/mc_port_fifo.sv
// rtl/mc_port_fifo.sv - synchronous fifo primitive with occupancy count
// Ports: clk, reset (async, active-high); push/wdata write side; pop/rdata read side
// (rdata is the current head); empty, full, count status.
// A push while full is accepted only when a pop happens on the same edge.
module mc_port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

endmodule

// File: rtl/mc_port_ram.sv
// rtl/mc_port_ram.sv - simple dual-port synchronous RAM, write-first
// Ports: clk; we/waddr/wdata write port; re/raddr read port with registered rdata.
// A read of the address being written on the same edge returns the new data.
// No reset: contents survive a controller reset.
module mc_port_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 64
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/mc_port_responder.sv
// rtl/mc_port_responder.sv - MC-side port responder servicing ld/st from on-chip RAM
// Ports: clk, reset (async, active-high); request mc_req_ld/st/vadr/wrd_rdctl;
// advisory mc_rd_rq_stall/mc_wr_rq_stall; response mc_rsp_push/rdctl/data with
// mc_rsp_stall back-pressure; sticky err; req_count of accepted requests.
// Optional: MC_ADDR_CHECK_EN flags and neutralises addresses beyond the RAM.
module mc_port_responder
    import mc_port_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4,
    parameter int QDEPTH     = 32,
    parameter int RSPQ       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mc_req_ld,
    input  logic               mc_req_st,
    input  logic [VADR_W-1:0]  mc_req_vadr,
    input  logic [WRD_W-1:0]   mc_req_wrd_rdctl,
    output logic               mc_rd_rq_stall,
    output logic               mc_wr_rq_stall,
    output logic [RDCTL_W-1:0] mc_rsp_rdctl,
    output logic [WRD_W-1:0]   mc_rsp_data,
    output logic               mc_rsp_push,
    input  logic               mc_rsp_stall,
    output logic               err,
    output logic [31:0]        req_count
);

    localparam int NSTG = LATENCY - 3;
    localparam int QCW  = $clog2(QDEPTH) + 1;
    localparam int RCW  = $clog2(RSPQ) + 1;

    req_entry_t       req_in;
    req_entry_t       req_head;
    logic             req_any;
    logic             req_push;
    logic             req_pop;
    logic             req_drop;
    logic             req_empty;
    logic             req_full;
    logic [QCW-1:0]   req_cnt;
    logic             req_oob;
    logic             unused_hi;
    logic             unused_bits;
    logic             err_set;

    logic             rq_stall;
    logic             rsp_stall_r;
    logic [4:0]       inflight;
    logic [7:0]       occ;
    logic             pop_ld;
    logic             pop_st;

    logic             p_valid;
    logic [RDCTL_W-1:0] p_tag;
    logic             p_oob;
    logic [WRD_W-1:0] ram_rdata;
    rsp_entry_t       s0;
    rsp_entry_t       rq_in;
    logic             rq_in_valid;

    rsp_entry_t       rsp_head;
    logic             rsp_empty;
    logic             rsp_full;
    logic [RCW-1:0]   rsp_cnt;

`ifdef MC_ADDR_CHECK_EN
    assign req_oob   = |mc_req_vadr[VADR_W-1:DEPTH_LOG2+3];
    assign unused_hi = 1'b0;
`else
    assign req_oob   = 1'b0;
    assign unused_hi = |mc_req_vadr[VADR_W-1:DEPTH_LOG2+3];
`endif
    assign unused_bits = ^{rsp_full, req_head.wadr, unused_hi};

    // ---------------- request side ----------------
    assign req_any  = mc_req_ld | mc_req_st;
    assign req_drop = req_any & req_full & ~req_pop;
    assign req_push = req_any & ~req_drop;
    assign err_set  = (mc_req_ld & mc_req_st) | (req_any & |mc_req_vadr[2:0])
                    | req_drop | (req_any & req_oob);

    always_comb begin
        req_in         = '0;
        req_in.is_st   = mc_req_st & ~mc_req_ld;
        req_in.oob     = req_oob;
        req_in.wadr    = WADR_W'(mc_req_vadr[DEPTH_LOG2+2:3]);
        req_in.payload = mc_req_wrd_rdctl;
    end

    mc_port_fifo #(.WIDTH($bits(req_entry_t)), .DEPTH(QDEPTH)) u_reqq (
        .clk   (clk),
        .reset (reset),
        .push  (req_push),
        .wdata (req_in),
        .pop   (req_pop),
        .rdata (req_head),
        .empty (req_empty),
        .full  (req_full),
        .count (req_cnt)
    );

    // Loads pop only if their response is guaranteed a slot in the response queue.
    assign occ     = 8'(rsp_cnt) + 8'(inflight);
    assign req_pop = ~req_empty & (req_head.is_st | (occ < 8'(RSPQ)));
    assign pop_ld  = req_pop & ~req_head.is_st;
    assign pop_st  = req_pop & req_head.is_st;

    mc_port_ram #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WRD_W)) u_ram (
        .clk   (clk),
        .we    (pop_st & ~req_head.oob),
        .waddr (req_head.wadr[DEPTH_LOG2-1:0]),
        .wdata (req_head.payload),
        .re    (pop_ld),
        .raddr (req_head.wadr[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err         <= 1'b0;
            req_count   <= '0;
            rq_stall    <= 1'b0;
            rsp_stall_r <= 1'b0;
            inflight    <= '0;
            p_valid     <= 1'b0;
        end else begin
            err         <= err | err_set;
            if (req_push) req_count <= req_count + 32'd1;
            rq_stall    <= (req_cnt >= QCW'(QDEPTH - 4));
            rsp_stall_r <= mc_rsp_stall;
            inflight    <= inflight + 5'(pop_ld) - 5'(rq_in_valid);
            p_valid     <= pop_ld;
        end
    end

    // Tag travels alongside the synchronous RAM read.
    always_ff @(posedge clk) begin
        if (pop_ld) begin
            p_tag <= req_head.payload[RDCTL_W-1:0];
            p_oob <= req_head.oob;
        end
    end

    always_comb begin
        s0       = '0;
        s0.rdctl = p_tag;
        s0.data  = p_oob ? '0 : ram_rdata;
    end

    // ---------------- LATENCY-3 delay stages ----------------
    generate
        if (NSTG == 0) begin : g_nodly
            assign rq_in_valid = p_valid;
            assign rq_in       = s0;
        end else begin : g_dly
            logic [NSTG-1:0] v;
            rsp_entry_t      e [NSTG];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v <= '0;
                end else begin
                    v[0] <= p_valid;
                    for (int i = 1; i < NSTG; i++) v[i] <= v[i-1];
                end
            end

            always_ff @(posedge clk) begin
                e[0] <= s0;
                for (int i = 1; i < NSTG; i++) e[i] <= e[i-1];
            end

            assign rq_in_valid = v[NSTG-1];
            assign rq_in       = e[NSTG-1];
        end
    endgenerate

    // ---------------- response side ----------------
    mc_port_fifo #(.WIDTH($bits(rsp_entry_t)), .DEPTH(RSPQ)) u_rspq (
        .clk   (clk),
        .reset (reset),
        .push  (rq_in_valid),
        .wdata (rq_in),
        .pop   (mc_rsp_push),
        .rdata (rsp_head),
        .empty (rsp_empty),
        .full  (rsp_full),
        .count (rsp_cnt)
    );

    assign mc_rsp_push    = ~rsp_empty & ~rsp_stall_r;
    assign mc_rsp_rdctl   = mc_rsp_push ? rsp_head.rdctl : '0;
    assign mc_rsp_data    = mc_rsp_push ? rsp_head.data  : '0;
    assign mc_rd_rq_stall = rq_stall;
    assign mc_wr_rq_stall = rq_stall;

endmodule

// File: tb/tb_mc_port_responder.sv
// tb/tb_mc_port_responder.sv - directed self-checking bench for mc_port_responder
module tb_mc_port_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mc_req_ld = 1'b0;
    logic        mc_req_st = 1'b0;
    logic [47:0] mc_req_vadr = '0;
    logic [63:0] mc_req_wrd_rdctl = '0;
    logic        mc_rd_rq_stall;
    logic        mc_wr_rq_stall;
    logic [31:0] mc_rsp_rdctl;
    logic [63:0] mc_rsp_data;
    logic        mc_rsp_push;
    logic        mc_rsp_stall = 1'b0;
    logic        err;
    logic [31:0] req_count;

    int          n_vec = 0;
    int          n_miss = 0;
    int          n_push = 0;
    logic [31:0] mon_tag[$];
    logic [63:0] mon_data[$];
    logic        rd_stall_q = 1'b0;
    logic        wr_stall_q = 1'b0;
    logic        stall_seen = 1'b0;
    int          snap0, snap1, snap2;

    mc_port_responder dut (
        .clk              (clk),
        .reset            (reset),
        .mc_req_ld        (mc_req_ld),
        .mc_req_st        (mc_req_st),
        .mc_req_vadr      (mc_req_vadr),
        .mc_req_wrd_rdctl (mc_req_wrd_rdctl),
        .mc_rd_rq_stall   (mc_rd_rq_stall),
        .mc_wr_rq_stall   (mc_wr_rq_stall),
        .mc_rsp_rdctl     (mc_rsp_rdctl),
        .mc_rsp_data      (mc_rsp_data),
        .mc_rsp_push      (mc_rsp_push),
        .mc_rsp_stall     (mc_rsp_stall),
        .err              (err),
        .req_count        (req_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_stall_q <= mc_rd_rq_stall;
        wr_stall_q <= mc_wr_rq_stall;
    end

    always @(negedge clk) begin
        if (mc_rd_rq_stall) stall_seen = 1'b1;
        if (mc_rsp_push) begin
            n_push++;
            mon_tag.push_back(mc_rsp_rdctl);
            mon_data.push_back(mc_rsp_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit ld, input bit st, input logic [47:0] a, input logic [63:0] w);
        @(posedge clk);
        #1;
        mc_req_ld        = ld;
        mc_req_st        = st;
        mc_req_vadr      = a;
        mc_req_wrd_rdctl = w;
    endtask

    task automatic clear_mon();
        mon_tag.delete();
        mon_data.delete();
    endtask

    task automatic check_rsp(input string tag, input int n, input logic [31:0] tag_base,
                             input logic [63:0] data_base);
        check({tag, "_count"}, 64'(mon_tag.size()), 64'(n));
        for (int i = 0; i < n && i < mon_tag.size(); i++) begin
            check({tag, "_rdctl"}, 64'(mon_tag[i]), 64'(tag_base + 32'(i)));
            check({tag, "_data"}, mon_data[i], data_base + 64'(i));
        end
    endtask

    // Issue n requests to words 0..n-1, obeying the registered stall copy.
    // mc_rsp_stall is raised at cycle stall_on and dropped at cycle stall_off.
    task automatic burst(input int n, input bit is_st, input logic [31:0] tag_base,
                         input int stall_on, input int stall_off);
        int sent = 0;
        int cyc = 0;
        while ((sent < n || cyc <= stall_off) && cyc < 2000) begin
            @(posedge clk);
            #1;
            if (cyc == stall_on)  mc_rsp_stall = 1'b1;
            if (cyc == stall_off) mc_rsp_stall = 1'b0;
            if (cyc == stall_on)  snap0 = n_push;
            if (sent < n && !(is_st ? wr_stall_q : rd_stall_q)) begin
                mc_req_ld        = !is_st;
                mc_req_st        = is_st;
                mc_req_vadr      = 48'(sent * 8);
                mc_req_wrd_rdctl = is_st ? 64'(32'h1000 + sent) : 64'(tag_base + 32'(sent));
                sent++;
            end else begin
                mc_req_ld = 1'b0;
                mc_req_st = 1'b0;
            end
            @(negedge clk);
            #1;
            if (cyc == stall_on)      snap1 = n_push;
            if (cyc == stall_off - 1) snap2 = n_push;
            cyc++;
        end
        check("burst_sent", 64'(sent), 64'(n));
        drive(0, 0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_push", 64'(mc_rsp_push), 64'd0);
        check("rst_rdctl", 64'(mc_rsp_rdctl), 64'd0);
        check("rst_data", mc_rsp_data, 64'd0);
        check("rst_rd_stall", 64'(mc_rd_rq_stall), 64'd0);
        check("rst_wr_stall", 64'(mc_wr_rq_stall), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_req_count", 64'(req_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // idle load latency: push exactly LATENCY=4 cycles after presentation
        drive(0, 1, 48'h28, 64'hDEADBEEF);
        drive(0, 0, '0, '0);
        repeat (10) @(posedge clk);
        clear_mon();
        drive(1, 0, 48'h28, 64'h7);
        for (int c = 1; c <= 4; c++) begin
            drive(0, 0, '0, '0);
            @(negedge clk);
            if (c < 4) begin
                check("lat_early_push", 64'(mc_rsp_push), 64'd0);
            end else begin
                check("lat_push", 64'(mc_rsp_push), 64'd1);
                check("lat_data", mc_rsp_data, 64'hDEADBEEF);
                check("lat_rdctl", 64'(mc_rsp_rdctl), 64'h7);
            end
        end
        repeat (5) @(posedge clk);
        clear_mon();

        // store then load to the same word on consecutive cycles
        drive(0, 1, 48'h40, 64'h1234);
        drive(1, 0, 48'h40, 64'h11);
        drive(0, 0, '0, '0);
        repeat (15) @(posedge clk);
        check_rsp("st_ld", 1, 32'h11, 64'h1234);
        check("req_count4", 64'(req_count), 64'd4);
        clear_mon();

        // preload words 0..39 = 0x1000+i, then 40 loads against a stalled consumer
        burst(40, 1'b1, 32'h0, -1, -1);
        repeat (10) @(posedge clk);
        clear_mon();
        burst(40, 1'b0, 32'h100, 0, 50);
        repeat (80) @(posedge clk);
        check("rq_stall_seen", 64'(stall_seen), 64'd1);
        check_rsp("b40", 40, 32'h100, 64'h1000);
        check("b40_err", 64'(err), 64'd0);
        clear_mon();

        // consumer stall held 20 cycles during 16 loads
        burst(16, 1'b0, 32'h200, 6, 26);
        repeat (40) @(posedge clk);
        check("stall_skid_le1", 64'((snap1 - snap0) <= 1), 64'd1);
        check("stall_hold_pushes", 64'(snap2 - snap1), 64'd0);
        check_rsp("b16", 16, 32'h200, 64'h1000);
        check("b16_err", 64'(err), 64'd0);
        clear_mon();

        // ld and st together
        drive(1, 1, 48'h10, 64'h5);
        drive(0, 0, '0, '0);
        @(negedge clk);
        check("err_ldst", 64'(err), 64'd1);
        do_reset();
        @(negedge clk);
        check("err_cleared", 64'(err), 64'd0);

        // misaligned address, sticky
        drive(1, 0, 48'h43, 64'h9);
        drive(0, 0, '0, '0);
        @(negedge clk);
        check("err_misalign", 64'(err), 64'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("err_sticky", 64'(err), 64'd1);

        // async reset mid-burst
        for (int i = 0; i < 10; i++) drive(1, 0, 48'(i * 8), 64'(32'h300 + i));
        @(posedge clk);
        #1;
        mc_req_ld = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_push", 64'(mc_rsp_push), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_count", 64'(req_count), 64'd0);
        check("mid_rst_stall", 64'(mc_rd_rq_stall), 64'd0);
        check("mid_rst_data", mc_rsp_data, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        snap0 = n_push;
        repeat (20) @(posedge clk);
        check("flush_no_push", 64'(n_push - snap0), 64'd0);
        clear_mon();

        // RAM retained across reset
        drive(1, 0, 48'h18, 64'h33);
        drive(0, 0, '0, '0);
        repeat (10) @(posedge clk);
        check_rsp("retain", 1, 32'h33, 64'h1003);
        check("retain_count", 64'(req_count), 64'd1);
        check("retain_err", 64'(err), 64'd0);
        clear_mon();

        // address beyond the RAM
        drive(1, 0, 48'h2000, 64'h44);
        drive(0, 0, '0, '0);
        repeat (10) @(posedge clk);
`ifdef MC_ADDR_CHECK_EN
        check_rsp("oob", 1, 32'h44, 64'h0);
        check("oob_err", 64'(err), 64'd1);
`else
        check_rsp("alias", 1, 32'h44, 64'h1000);
        check("alias_err", 64'(err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
